// File: rtl/modport_decoder.sv
// RV32I decoder. It latches one instruction, sends its source register addresses over a
// shared port one at a time, then holds the decode until execute and downstream release it.
module modport_decoder #(
    parameter int BUS_WIDTH    = 32,
    parameter int OPCODE_WIDTH = 7,
    parameter int ADDR_WIDTH   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    input  logic [BUS_WIDTH-1:0]    instr,
    input  logic [OPCODE_WIDTH-1:0] op_done,
    input  logic                    next_instr,
    output logic [BUS_WIDTH-1:0]    imme_value,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [ADDR_WIDTH-1:0]   rs_addr,
    output logic                    rs_addr_sel,
    output logic                    rs_addr_valid
);

    localparam logic [OPCODE_WIDTH-1:0] OPC_OP     = OPCODE_WIDTH'(7'b0110011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_STORE  = OPCODE_WIDTH'(7'b0100011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_BRANCH = OPCODE_WIDTH'(7'b1100011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_OPIMM  = OPCODE_WIDTH'(7'b0010011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD   = OPCODE_WIDTH'(7'b0000011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_JALR   = OPCODE_WIDTH'(7'b1100111);
    localparam logic [OPCODE_WIDTH-1:0] OPC_LUI    = OPCODE_WIDTH'(7'b0110111);
    localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC  = OPCODE_WIDTH'(7'b0010111);
    localparam logic [OPCODE_WIDTH-1:0] OPC_JAL    = OPCODE_WIDTH'(7'b1101111);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RS1,
        S_RS2,
        S_WAIT_DONE,
        S_HOLD
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_rs1;
    logic [ADDR_WIDTH-1:0]   r_rs2;
    logic                    r_use_rs2;
    logic [OPCODE_WIDTH-1:0] w_opc;
    logic                    w_accept;
    logic                    w_legal;
    logic                    w_use_rs1;
    logic                    w_use_rs2;
    logic                    w_no_rd;
    logic                    w_unused;

    assign w_opc    = instr[OPCODE_WIDTH-1:0];
    assign w_accept = (r_state == S_IDLE) && instr_valid;
    assign w_unused = ^instr[14:12];

    function automatic logic [BUS_WIDTH-1:0] imm_decode(input logic [BUS_WIDTH-1:0] i);
        logic [OPCODE_WIDTH-1:0] op;
        op = i[OPCODE_WIDTH-1:0];
        case (op)
            OPC_OPIMM, OPC_LOAD, OPC_JALR:
                imm_decode = {{(BUS_WIDTH-12){i[31]}}, i[31:20]};
            OPC_STORE:
                imm_decode = {{(BUS_WIDTH-12){i[31]}}, i[31:25], i[11:7]};
            OPC_BRANCH:
                imm_decode = {{(BUS_WIDTH-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_decode = {i[BUS_WIDTH-1:12], 12'b0};
            OPC_JAL:
                imm_decode = {{(BUS_WIDTH-21){i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:
                imm_decode = '0;
        endcase
    endfunction

    always_comb begin
        w_legal   = 1'b1;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_no_rd   = 1'b0;
        case (w_opc)
            OPC_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_no_rd   = 1'b1;
            end
            OPC_OPIMM, OPC_LOAD, OPC_JALR: w_use_rs1 = 1'b1;
            OPC_LUI, OPC_AUIPC, OPC_JAL:   w_use_rs1 = 1'b0;
            default:                       w_legal   = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                // An illegal opcode is zeroed on the outputs and the decoder stays ready.
                if (instr_valid && w_legal) begin
                    w_state_nxt = w_use_rs1 ? S_RS1 : S_WAIT_DONE;
                end
            end
            S_RS1:       w_state_nxt = r_use_rs2 ? S_RS2 : S_WAIT_DONE;
            S_RS2:       w_state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (op_done == opcode) w_state_nxt = S_HOLD;
            S_HOLD:      if (next_instr) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rs1     <= instr[15 +: ADDR_WIDTH];
            r_rs2     <= instr[20 +: ADDR_WIDTH];
            r_use_rs2 <= w_use_rs2;
        end
    end

    // Port outputs lag the state by one edge: the RS1/RS2 cycles are driven on leaving them.
    always_ff @(posedge clk) begin
        if (rst) begin
            imme_value    <= '0;
            opcode        <= '0;
            rd_addr       <= '0;
            rs_addr       <= '0;
            rs_addr_sel   <= 1'b0;
            rs_addr_valid <= 1'b0;
        end else begin
            rs_addr_valid <= (r_state == S_RS1) || (r_state == S_RS2);
            if (r_state == S_RS1) begin
                rs_addr     <= r_rs1;
                rs_addr_sel <= 1'b0;
            end else if (r_state == S_RS2) begin
                rs_addr     <= r_rs2;
                rs_addr_sel <= 1'b1;
            end
            if (w_accept) begin
                opcode     <= w_legal ? w_opc : '0;
                rd_addr    <= (w_legal && !w_no_rd) ? instr[7 +: ADDR_WIDTH] : '0;
                imme_value <= imm_decode(instr);
            end
        end
    end

endmodule

// File: tb/tb_modport_decoder.sv
// Bench for modport_decoder: directed instruction table, reset corner sequences and
// randomized instructions checked against a field-arithmetic reference decode.
module tb_modport_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  op_done;
    logic        next_instr;
    logic [31:0] imme_value;
    logic [6:0]  opcode;
    logic [4:0]  rd_addr;
    logic [4:0]  rs_addr;
    logic        rs_addr_sel;
    logic        rs_addr_valid;

    always #5 clk = ~clk;

    modport_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .op_done      (op_done),
        .next_instr   (next_instr),
        .imme_value   (imme_value),
        .opcode       (opcode),
        .rd_addr      (rd_addr),
        .rs_addr      (rs_addr),
        .rs_addr_sel  (rs_addr_sel),
        .rs_addr_valid(rs_addr_valid)
    );

    typedef struct {
        logic [31:0] w;
        logic        legal;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [31:0] imm;
        int          nrs;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[10];
    logic [6:0] ops[9] = '{7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h67, 7'h37, 7'h17, 7'h6F};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " imm"}, imme_value, 32'h0);
        chk({tag, " opcode"}, 32'(opcode), 32'h0);
        chk({tag, " rd"}, 32'(rd_addr), 32'h0);
        chk({tag, " rs_addr"}, 32'(rs_addr), 32'h0);
        chk({tag, " rs_sel"}, 32'(rs_addr_sel), 32'h0);
        chk({tag, " rs_valid"}, 32'(rs_addr_valid), 32'h0);
    endtask

    task automatic hold_chk(input vec_t v, input string tag);
        chk({tag, " opcode hold"}, 32'(opcode), 32'(v.opc));
        chk({tag, " rd hold"}, 32'(rd_addr), 32'(v.rd));
        chk({tag, " imm hold"}, imme_value, v.imm);
        chk({tag, " rs_valid low"}, 32'(rs_addr_valid), 32'h0);
    endtask

    // Reference decode built from field arithmetic on the instruction word.
    function automatic vec_t ref_model(input logic [31:0] w);
        vec_t v;
        int   s;
        s     = $signed(w);
        v.w   = w;
        v.legal = 1'b1;
        v.opc = w[6:0];
        v.rd  = w[11:7];
        v.imm = 32'h0;
        v.nrs = 0;
        v.rs1 = w[19:15];
        v.rs2 = w[24:20];
        case (w[6:0])
            7'h33: v.nrs = 2;
            7'h23: begin
                v.nrs = 2;
                v.rd  = 5'd0;
                v.imm = ((s >>> 25) <<< 5) | int'(w[11:7]);
            end
            7'h63: begin
                v.nrs = 2;
                v.rd  = 5'd0;
                v.imm = ((s >>> 31) <<< 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5)
                        | (int'(w[11:8]) << 1);
            end
            7'h13, 7'h03, 7'h67: begin
                v.nrs = 1;
                v.imm = s >>> 20;
            end
            7'h37, 7'h17: v.imm = w & 32'hFFFFF000;
            7'h6F: v.imm = ((s >>> 31) <<< 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11)
                           | (int'(w[30:21]) << 1);
            default: begin
                v.legal = 1'b0;
                v.opc   = 7'h0;
                v.rd    = 5'd0;
            end
        endcase
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        logic [31:0] g;
        logic [6:0]  d;
        logic [4:0]  last_a;
        int          n;
        int          h;
        instr_valid = 1'b1;
        instr       = v.w;
        op_done     = 7'h0;
        next_instr  = 1'($urandom_range(0, 1));
        cyc();
        instr_valid = 1'b0;
        chk({tag, " opcode"}, 32'(opcode), 32'(v.opc));
        chk({tag, " rd"}, 32'(rd_addr), 32'(v.rd));
        chk({tag, " imm"}, imme_value, v.imm);
        chk({tag, " rs_valid first"}, 32'(rs_addr_valid), 32'h0);
        if (!v.legal) begin
            next_instr = 1'b0;
            return;
        end
        // Ignored instr_valid/next_instr carry an illegal word: accepting it would zero the outputs.
        for (int i = 0; i < v.nrs; i++) begin
            g = $urandom;
            g[6:0] = 7'h7F;
            instr_valid = 1'b1;
            instr       = g;
            next_instr  = 1'($urandom_range(0, 1));
            cyc();
            chk({tag, " rs_valid"}, 32'(rs_addr_valid), 32'h1);
            chk({tag, " rs_addr"}, 32'(rs_addr), 32'((i == 0) ? v.rs1 : v.rs2));
            chk({tag, " rs_sel"}, 32'(rs_addr_sel), 32'(i));
            chk({tag, " opcode in rs"}, 32'(opcode), 32'(v.opc));
        end
        last_a = (v.nrs == 2) ? v.rs2 : v.rs1;
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) begin
            g = $urandom;
            g[6:0] = 7'h7F;
            d = 7'($urandom_range(0, 127));
            if (d == v.opc) d = 7'h0;
            instr_valid = 1'b1;
            instr       = g;
            op_done     = d;
            next_instr  = 1'($urandom_range(0, 1));
            cyc();
            hold_chk(v, {tag, " wait"});
            if (v.nrs > 0) begin
                chk({tag, " rs_addr held"}, 32'(rs_addr), 32'(last_a));
                chk({tag, " rs_sel held"}, 32'(rs_addr_sel), 32'(v.nrs == 2));
            end
        end
        op_done    = v.opc;
        next_instr = 1'($urandom_range(0, 1));
        cyc();
        op_done = 7'h0;
        hold_chk(v, {tag, " match"});
        h = $urandom_range(1, 3);
        for (int k = 0; k < h; k++) begin
            g = $urandom;
            g[6:0] = 7'h7F;
            instr_valid = 1'b1;
            instr       = g;
            next_instr  = (k == h - 1);
            cyc();
            hold_chk(v, {tag, " hold"});
        end
        instr_valid = 1'b0;
        next_instr  = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b1;
        instr       = 32'h002081B3;
        op_done     = 7'h33;
        next_instr  = 1'b1;
        cyc();
        cyc();
        all_zero("reset");
        rst         = 1'b0;
        instr_valid = 1'b0;
        op_done     = 7'h0;
        next_instr  = 1'b0;

        tbl[0] = '{32'h002081B3, 1'b1, 7'h33, 5'd3,  32'h00000000, 2, 5'd1, 5'd2};
        tbl[1] = '{32'hFFF00293, 1'b1, 7'h13, 5'd5,  32'hFFFFFFFF, 1, 5'd0, 5'd31};
        tbl[2] = '{32'h123453B7, 1'b1, 7'h37, 5'd7,  32'h12345000, 0, 5'd8, 5'd3};
        tbl[3] = '{32'h0020A423, 1'b1, 7'h23, 5'd0,  32'h00000008, 2, 5'd1, 5'd2};
        tbl[4] = '{32'hFE000EE3, 1'b1, 7'h63, 5'd0,  32'hFFFFFFFC, 2, 5'd0, 5'd0};
        tbl[5] = '{32'hFFFFFFFF, 1'b0, 7'h00, 5'd0,  32'h00000000, 0, 5'd0, 5'd0};
        tbl[6] = '{32'hFFC42303, 1'b1, 7'h03, 5'd6,  32'hFFFFFFFC, 1, 5'd8, 5'd28};
        tbl[7] = '{32'h004100E7, 1'b1, 7'h67, 5'd1,  32'h00000004, 1, 5'd2, 5'd4};
        tbl[8] = '{32'hFFFFF517, 1'b1, 7'h17, 5'd10, 32'hFFFFF000, 0, 5'd31, 5'd31};
        tbl[9] = '{32'h001000EF, 1'b1, 7'h6F, 5'd1,  32'h00000800, 0, 5'd0, 5'd1};
        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i], $sformatf("tbl%0d", i));
        end

        // Reset while the rs2 address is being driven.
        instr_valid = 1'b1;
        instr       = 32'h002081B3;
        cyc();
        instr_valid = 1'b0;
        cyc();
        chk("rst_rs2 rs1 cycle", 32'(rs_addr_valid), 32'h1);
        rst = 1'b1;
        cyc();
        all_zero("rst_rs2");
        rst = 1'b0;
        cyc();
        chk("rst_rs2 no resume", 32'(rs_addr_valid), 32'h0);
        chk("rst_rs2 opcode idle", 32'(opcode), 32'h0);
        run_txn(tbl[0], "after_rst");

        for (int k = 0; k < 40; k++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 7) == 0) w[6:0] = 7'h7F;
            else w[6:0] = ops[$urandom_range(0, 8)];
            run_txn(ref_model(w), $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
